// File: rtl/sevseg_scan_ctrl.sv
// Eight-digit common-anode seven-segment scan controller with prescaled ticks,
// per-slot PWM brightness, anti-ghost gap, leading-zero blanking and frame-synchronous shadowing.
module sevseg_scan_ctrl #(
    parameter int PRESC_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [PRESC_W-1:0] i_presc,
    input  logic [31:0]        i_digits,
    input  logic [7:0]         i_en,
    input  logic [7:0]         i_dp,
    input  logic [3:0]         i_duty,
    input  logic               i_lzb,
    output logic [7:0]         o_an,
    output logic [6:0]         o_seg,
    output logic               o_dp,
    output logic               o_frame
);

    // Active-low segments {a,b,c,d,e,f,g}
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0001100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b1110010;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    logic [PRESC_W-1:0] pc;
    logic [3:0]         ph;
    logic [2:0]         dig;
    logic               load_pend;

    logic [PRESC_W-1:0] sh_presc;
    logic [31:0]        sh_digits;
    logic [7:0]         sh_en;
    logic [7:0]         sh_dp;
    logic [3:0]         sh_duty;
    logic               sh_lzb;

    logic               tick;
    logic               frame_edge;
    logic [7:0]         lzb_blank;
    logic [3:0]         cur_nib;
    logic               lit;

    assign tick       = (pc == sh_presc);
    assign frame_edge = tick && (dig == 3'd7) && (ph == 4'd15);
    assign cur_nib    = sh_digits[{dig, 2'b00} +: 4];

    // A digit is blanked when it and every more-significant nibble are zero.
    always_comb begin
        // NOTE: assign a default before the loop so no bit is left unassigned (no latch).
        lzb_blank = '0;
        for (int d = 1; d < 8; d++) begin
            lzb_blank[d] = sh_lzb && ((sh_digits >> (4 * d)) == 32'd0);
        end
    end

    // Phase 0 of every slot stays dark to give the anode drivers time to turn off.
    assign lit = sh_en[dig] && (ph != 4'd0) && (ph <= sh_duty) && !lzb_blank[dig];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc        <= '0;
            ph        <= '0;
            dig       <= '0;
            load_pend <= 1'b1;
            sh_presc  <= '0;
            sh_digits <= '0;
            sh_en     <= '0;
            sh_dp     <= '0;
            sh_duty   <= '0;
            sh_lzb    <= 1'b0;
        end else if (load_pend) begin
            // First edge after reset: take a fresh configuration, scan starts at digit 0, phase 0.
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            load_pend <= 1'b0;
            sh_presc  <= i_presc;
            sh_digits <= i_digits;
            sh_en     <= i_en;
            sh_dp     <= i_dp;
            sh_duty   <= i_duty;
            sh_lzb    <= i_lzb;
        end else begin
            if (tick) begin
                pc <= '0;
                ph <= ph + 4'd1;
                if (ph == 4'd15) begin
                    dig <= dig + 3'd1;
                end
            end else begin
                pc <= pc + 1'b1;
            end
            if (frame_edge) begin
                sh_presc  <= i_presc;
                sh_digits <= i_digits;
                sh_en     <= i_en;
                sh_dp     <= i_dp;
                sh_duty   <= i_duty;
                sh_lzb    <= i_lzb;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_an    <= 8'hFF;
            o_seg   <= 7'h7F;
            o_dp    <= 1'b1;
            o_frame <= 1'b0;
        end else begin
            o_an    <= lit ? ~(8'b1 << dig) : 8'hFF;
            o_seg   <= lit ? seg_decode(cur_nib) : 7'h7F;
            o_dp    <= lit ? ~sh_dp[dig] : 1'b1;
            o_frame <= frame_edge && !load_pend;
        end
    end

endmodule

// File: tb/tb_sevseg_scan_ctrl.sv
// Directed bench for sevseg_scan_ctrl: frame-by-frame cycle comparison plus
// hand-computed lit masks and lit-cycle counts per scenario.
module tb_sevseg_scan_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [15:0] i_presc = '0;
    logic [31:0] i_digits = '0;
    logic [7:0]  i_en = '0;
    logic [7:0]  i_dp = '0;
    logic [3:0]  i_duty = '0;
    logic        i_lzb = 1'b0;
    logic [7:0]  o_an;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic        o_frame;

    int n_pass  = 0;
    int n_total = 0;

    always #5 i_clk = ~i_clk;

    sevseg_scan_ctrl #(.PRESC_W(16)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_presc (i_presc),
        .i_digits(i_digits),
        .i_en    (i_en),
        .i_dp    (i_dp),
        .i_duty  (i_duty),
        .i_lzb   (i_lzb),
        .o_an    (o_an),
        .o_seg   (o_seg),
        .o_dp    (o_dp),
        .o_frame (o_frame)
    );

    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;  4'h9: s = 7'b0001100;
            4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
            4'hC: s = 7'b1110010;  4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;  default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    task automatic set_cfg(input logic [15:0] presc, input logic [3:0] duty, input logic [7:0] en,
                           input logic [31:0] digits, input logic [7:0] dp, input logic lzb);
        i_presc  = presc;
        i_duty   = duty;
        i_en     = en;
        i_digits = digits;
        i_dp     = dp;
        i_lzb    = lzb;
    endtask

    // Called at the negedge just after a frame edge (or the post-reset load edge);
    // walks one whole frame and ends at the negedge after the next frame edge.
    task automatic run_frame(input string name, input logic [15:0] presc, input logic [3:0] duty,
                             input logic [7:0] en, input logic [31:0] digits, input logic [7:0] dp,
                             input logic lzb, input int mid_k, input logic [31:0] mid_digits,
                             output logic [7:0] low_mask, output int low_cnt);
        int         len, j, t, ph, dg;
        logic       lzbd, lit, bad, e_dp, e_fr;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        len      = 128 * (int'(presc) + 1);
        bad      = 1'b0;
        low_mask = '0;
        low_cnt  = 0;
        for (int k = 1; k <= len; k++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            j     = k - 1;
            t     = j / (int'(presc) + 1);
            ph    = t % 16;
            dg    = t / 16;
            lzbd  = (dg != 0) && lzb && ((digits >> (4 * dg)) == 32'd0);
            lit   = en[dg] && (ph >= 1) && (ph <= int'(duty)) && !lzbd;
            e_an  = lit ? ~(8'h01 << dg) : 8'hFF;
            e_seg = lit ? exp_seg(digits[4*dg +: 4]) : 7'h7F;
            e_dp  = lit ? ~dp[dg] : 1'b1;
            e_fr  = (k == len);
            if (!bad && (o_an !== e_an || o_seg !== e_seg || o_dp !== e_dp || o_frame !== e_fr)) begin
                bad = 1'b1;
                $display("FAIL %s cycle %0d: an=%h want %h, seg=%b want %b, dp=%b want %b, frame=%b want %b",
                         name, k, o_an, e_an, o_seg, e_seg, o_dp, e_dp, o_frame, e_fr);
            end
            if (o_an !== 8'hFF) begin
                low_mask = low_mask | ~o_an;
                low_cnt++;
            end
            if (k == mid_k) i_digits = mid_digits;
        end
        n_total++;
        if (!bad) n_pass++;
    endtask

    task automatic check_lit(input string name, input logic [7:0] mask, input int cnt,
                             input logic [7:0] want_mask, input int want_cnt);
        n_total++;
        if (mask !== want_mask || cnt != want_cnt)
            $display("FAIL %s: lit mask %h want %h, lit cycles %0d want %0d", name, mask, want_mask, cnt, want_cnt);
        else
            n_pass++;
    endtask

    task automatic check_dark(input string name);
        n_total++;
        if (o_an !== 8'hFF || o_seg !== 7'h7F || o_dp !== 1'b1 || o_frame !== 1'b0)
            $display("FAIL %s: an=%h seg=%b dp=%b frame=%b, want FF/1111111/1/0", name, o_an, o_seg, o_dp, o_frame);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        #2 i_rst = 1'b1;
        #1;
        check_dark("reset_async");
        set_cfg(16'd0, 4'd15, 8'hFF, 32'h76543210, 8'h01, 1'b0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_dark("reset_held");
        i_rst = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        check_dark("load_edge");
    endtask

    task automatic test_scan_basic();
        logic [7:0] m;
        int         c;
        run_frame("scan_p0_f1", 16'd0, 4'd15, 8'hFF, 32'h76543210, 8'h01, 1'b0, -1, 32'h0, m, c);
        check_lit("scan_p0_f1_lit", m, c, 8'hFF, 120);
        set_cfg(16'd3, 4'd4, 8'hFF, 32'h76543210, 8'h01, 1'b0);
        run_frame("scan_p0_f2", 16'd0, 4'd15, 8'hFF, 32'h76543210, 8'h01, 1'b0, -1, 32'h0, m, c);
        check_lit("scan_p0_f2_lit", m, c, 8'hFF, 120);
    endtask

    task automatic test_presc3();
        logic [7:0] m;
        int         c;
        set_cfg(16'd0, 4'd15, 8'hFF, 32'h00000120, 8'h00, 1'b1);
        run_frame("presc3", 16'd3, 4'd4, 8'hFF, 32'h76543210, 8'h01, 1'b0, -1, 32'h0, m, c);
        check_lit("presc3_lit", m, c, 8'hFF, 128);
    endtask

    task automatic test_lzb();
        logic [7:0] m;
        int         c;
        set_cfg(16'd0, 4'd15, 8'hFF, 32'h00000000, 8'h00, 1'b1);
        run_frame("lzb_120", 16'd0, 4'd15, 8'hFF, 32'h00000120, 8'h00, 1'b1, -1, 32'h0, m, c);
        check_lit("lzb_120_lit", m, c, 8'h07, 45);
        set_cfg(16'd0, 4'd15, 8'hFF, 32'h11111111, 8'h00, 1'b0);
        run_frame("lzb_zero", 16'd0, 4'd15, 8'hFF, 32'h00000000, 8'h00, 1'b1, -1, 32'h0, m, c);
        check_lit("lzb_zero_lit", m, c, 8'h01, 15);
    endtask

    task automatic test_mid_frame();
        logic [7:0] m;
        int         c;
        run_frame("mid_old", 16'd0, 4'd15, 8'hFF, 32'h11111111, 8'h00, 1'b0, 55, 32'h22222222, m, c);
        check_lit("mid_old_lit", m, c, 8'hFF, 120);
        set_cfg(16'd0, 4'd15, 8'h00, 32'h22222222, 8'h00, 1'b0);
        run_frame("mid_new", 16'd0, 4'd15, 8'hFF, 32'h22222222, 8'h00, 1'b0, -1, 32'h0, m, c);
        check_lit("mid_new_lit", m, c, 8'hFF, 120);
    endtask

    task automatic test_dark();
        logic [7:0] m;
        int         c;
        run_frame("en0_f1", 16'd0, 4'd15, 8'h00, 32'h22222222, 8'h00, 1'b0, -1, 32'h0, m, c);
        check_lit("en0_f1_lit", m, c, 8'h00, 0);
        set_cfg(16'd0, 4'd0, 8'hFF, 32'h22222222, 8'h00, 1'b0);
        run_frame("en0_f2", 16'd0, 4'd15, 8'h00, 32'h22222222, 8'h00, 1'b0, -1, 32'h0, m, c);
        check_lit("en0_f2_lit", m, c, 8'h00, 0);
        run_frame("duty0_f1", 16'd0, 4'd0, 8'hFF, 32'h22222222, 8'h00, 1'b0, -1, 32'h0, m, c);
        check_lit("duty0_f1_lit", m, c, 8'h00, 0);
        set_cfg(16'd0, 4'd15, 8'hFF, 32'h76543210, 8'h01, 1'b0);
        run_frame("duty0_f2", 16'd0, 4'd0, 8'hFF, 32'h22222222, 8'h00, 1'b0, -1, 32'h0, m, c);
        check_lit("duty0_f2_lit", m, c, 8'h00, 0);
    endtask

    task automatic test_reset_mid();
        logic [7:0] m;
        int         c;
        repeat (10) @(negedge i_clk);
        n_total++;
        if (o_an !== 8'hFE || o_seg !== 7'b0000001 || o_dp !== 1'b0)
            $display("FAIL pre_reset_lit: an=%h seg=%b dp=%b, want FE/0000001/0", o_an, o_seg, o_dp);
        else
            n_pass++;
        #2 i_rst = 1'b1;
        #1;
        check_dark("reset_mid_async");
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        check_dark("reset_mid_load");
        run_frame("restart", 16'd0, 4'd15, 8'hFF, 32'h76543210, 8'h01, 1'b0, -1, 32'h0, m, c);
        check_lit("restart_lit", m, c, 8'hFF, 120);
    endtask

    initial begin
        test_reset();
        test_scan_basic();
        test_presc3();
        test_lzb();
        test_mid_frame();
        test_dark();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
